lcd_bus_responder: RTL and testbench
====================================

LCD_BUS_RESPONDER -- requirements
Module: lcd_bus_responder

Interface
REQ-001 SHALL have parameter BUSY_SHORT, default 40, meaning busy length in clk cycles for ordinary commands and data writes.
REQ-002 SHALL have parameter BUSY_LONG, default 1640, meaning busy length for clear/home; it SHALL be at least 32.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 lcd_en, lcd_rs, lcd_rw  in  1 each  HD44780-style bus strobes from the LCD controller; asynchronous to clk.
REQ-006 lcd_data_in  in  8  bus data driven by the controller.
REQ-007 lcd_data_out  out  8  read data; lcd_data_oe  out  1  drive enable.
REQ-008 busy  out  1  busy flag.
REQ-009 ac  out  7  address counter.
REQ-010 disp_on, cursor_on, blink_on  out  1 each  display-control state.
REQ-011 mon_idx  in  5  monitor cell index; mon_char  out  8  registered DDRAM[mon_idx] (1-cycle latency).
REQ-012 cmd_count  out  16  count of accepted writes, saturating at 0xFFFF.
REQ-013 err_busy, err_addr  out  1 each  sticky error flags; err_clr  in  1  clears both.

Function
REQ-014 lcd_en SHALL pass through a 2-flop synchronizer; rs/rw/data SHALL be registered alongside its first stage; the falling-edge detect is an event; the write action and busy assertion occur on the cycle after the event.
REQ-015 DDRAM SHALL be 32x8: line 1 at AC 0x00-0x0F, line 2 at 0x40-0x4F; cell index = {AC[6],AC[3:0]}.
REQ-016 On an event with rw=0 while busy=0, the write SHALL be accepted: busy loads BUSY_SHORT (BUSY_LONG for clear/home) and counts down to 0; cmd_count increments.
REQ-017 On an event with rw=0 while busy=1, the write SHALL be ignored and err_busy set.
REQ-018 Commands (rs=0) SHALL be decoded by highest set bit: 0x01 clear, 0x02-0x03 home, 0x04-0x07 entry mode (I/D=bit1; S ignored), 0x08-0x0F display control (D, C, B = bits 2, 1, 0), 0x10-0x1F shift, 0x20-0x3F function set, 0x40-0x7F CGRAM address, 0x80-0xFF set DDRAM address; 0x00 SHALL be accepted with no effect.
REQ-019 Clear SHALL write 0x20 into one cell per cycle, cells 0 to 31, during busy, then set AC=0 and I/D=1.
REQ-020 Home SHALL set AC=0 and leave DDRAM unchanged.
REQ-021 Shift with S/C=0 SHALL move AC by one (R/L=bit2: 1 = increment) using the wrap rule of REQ-023; with S/C=1 it SHALL have no effect.
REQ-022 Set DDRAM address SHALL load AC=data[6:0] if the address is in the map; otherwise AC is unchanged and err_addr is set; the write still counts as accepted.
REQ-023 A data write (rs=1) SHALL store data at AC and step AC per I/D; the increment wraps 0x0F to 0x40 and 0x4F to 0x00, and the decrement wraps the reverse way.
REQ-024 Function set and CGRAM address SHALL be accepted with no effect.
REQ-025 While the synchronized lcd_en=1 and rw=1, lcd_data_oe SHALL be 1: with rs=0, data_out={busy,ac}; with rs=1, data_out=DDRAM[AC]. Reads SHALL be allowed while busy.
REQ-026 A data read SHALL step AC per I/D on its falling-edge event if busy=0; a status read SHALL never change state.
REQ-027 If err_clr and a new error occur in the same cycle, the error SHALL win.

Reset
REQ-028 rst low SHALL immediately set: lcd_data_out=0, lcd_data_oe=0, busy=0, ac=0, disp_on, cursor_on and blink_on=0, I/D=1, all DDRAM=0x20, mon_char=0x20, cmd_count=0, err_busy=0, err_addr=0.
REQ-029 Reset during busy or a clear SHALL abort it; the first event after release SHALL be handled normally.

Structure
REQ-030 Package lcd_resp_pkg SHALL hold the opcode constants, the BUSY defaults, LINE2_BASE=0x40, and SPACE=0x20.
REQ-031 Sub-module en_sync_edge SHALL implement the 2-flop synchronizer and the rise/fall detect.

Verification
REQ-032 Write 0x0C -> disp_on=1, cursor_on=0, blink_on=0; busy high for 40 cycles; cmd_count=1.
REQ-033 Write 0x8F, then data 0x41 and 0x42 -> DDRAM[15]=0x41, DDRAM[16]=0x42, ac=0x41.
REQ-034 Write 0x01, then a data write 10 cycles later -> err_busy=1, write ignored; after 1640 cycles all cells=0x20 and ac=0.
REQ-035 Status read during busy after 0x80 -> lcd_data_out=0x80; after busy ends -> 0x00; ac unchanged.
REQ-036 Write 0x95 -> err_addr=1, ac unchanged; err_clr pulse -> err_addr=0; rst mid-busy -> busy=0 at once.

Source files
------------

// File: rtl/lcd_resp_pkg.sv
// Shared constants, bus payload type and helpers for the HD44780-style bus responder.
package lcd_resp_pkg;

  localparam int unsigned BUSY_SHORT_DEF = 40;
  localparam int unsigned BUSY_LONG_DEF  = 1640;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned AC_W           = 7;
  localparam int unsigned CELLS          = 32;
  localparam int unsigned CELL_W         = 5;
  localparam int unsigned COUNT_W        = 16;

  localparam logic [AC_W-1:0]   LINE2_BASE = 7'h40;
  localparam logic [AC_W-1:0]   LINE1_LAST = 7'h0F;
  localparam logic [AC_W-1:0]   LINE2_LAST = 7'h4F;
  localparam logic [DATA_W-1:0] SPACE      = 8'h20;

  localparam logic [DATA_W-1:0] OP_CLEAR = 8'h01;
  localparam logic [DATA_W-1:0] OP_HOME  = 8'h02;
  localparam logic [DATA_W-1:0] OP_ENTRY = 8'h04;
  localparam logic [DATA_W-1:0] OP_DISP  = 8'h08;
  localparam logic [DATA_W-1:0] OP_SHIFT = 8'h10;
  localparam logic [DATA_W-1:0] OP_FUNC  = 8'h20;
  localparam logic [DATA_W-1:0] OP_CGRAM = 8'h40;
  localparam logic [DATA_W-1:0] OP_DDRAM = 8'h80;

  typedef struct packed {
    logic              rs;
    logic              rw;
    logic [DATA_W-1:0] data;
  } bus_sample_t;

  typedef enum logic [3:0] {
    CMD_NOP, CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISP,
    CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM
  } cmd_t;

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_BUSY} state_t;

  // Instruction class is chosen by the highest set bit.
  function automatic cmd_t decode_cmd(input logic [DATA_W-1:0] d);
    cmd_t c;
    casez (d)
      8'b1???????: c = CMD_DDRAM;
      8'b01??????: c = CMD_CGRAM;
      8'b001?????: c = CMD_FUNC;
      8'b0001????: c = CMD_SHIFT;
      8'b00001???: c = CMD_DISP;
      8'b000001??: c = CMD_ENTRY;
      8'b0000001?: c = CMD_HOME;
      8'b00000001: c = CMD_CLEAR;
      default:     c = CMD_NOP;
    endcase
    return c;
  endfunction

  // Address counter step with the two-line wrap: 0x0F<->0x40 and 0x4F<->0x00.
  function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] a, input logic inc);
    logic [AC_W-1:0] nxt;
    if (inc) begin
      if (a == LINE1_LAST)      nxt = LINE2_BASE;
      else if (a == LINE2_LAST) nxt = '0;
      else                      nxt = a + AC_W'(1);
    end else begin
      if (a == '0)              nxt = LINE2_LAST;
      else if (a == LINE2_BASE) nxt = LINE1_LAST;
      else                      nxt = a - AC_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/lcd_bus_responder_if.sv
// LCD controller bus: strobes and data from the controller, read data back to it.
interface lcd_bus_responder_if;
  import lcd_resp_pkg::*;

  logic              lcd_en;
  logic              lcd_rs;
  logic              lcd_rw;
  logic [DATA_W-1:0] lcd_data_in;
  logic [DATA_W-1:0] lcd_data_out;
  logic              lcd_data_oe;

  modport master (output lcd_en, lcd_rs, lcd_rw, lcd_data_in,
                  input  lcd_data_out, lcd_data_oe);
  modport slave  (input  lcd_en, lcd_rs, lcd_rw, lcd_data_in,
                  output lcd_data_out, lcd_data_oe);
endinterface

// File: rtl/en_sync_edge.sv
// Two-flop synchronizer for the asynchronous enable strobe plus rise/fall detect.
module en_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic en_async,
  output logic en_sync,
  output logic rise_c,
  output logic fall_c
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= en_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign en_sync = s2;
  assign rise_c  = s2 & ~s3;
  assign fall_c  = ~s2 & s3;
endmodule

// File: rtl/lcd_bus_responder.sv
// HD44780-style bus responder: decodes controller writes/reads against a 32-cell DDRAM model.
module lcd_bus_responder
  import lcd_resp_pkg::*;
#(
  parameter int unsigned BUSY_SHORT = BUSY_SHORT_DEF,
  parameter int unsigned BUSY_LONG  = BUSY_LONG_DEF
) (
  input  logic                clk,
  input  logic                rst,
  lcd_bus_responder_if.slave  bus,
  input  logic [CELL_W-1:0]   mon_idx,
  output logic [DATA_W-1:0]   mon_char,
  output logic                busy,
  output logic [AC_W-1:0]     ac,
  output logic                disp_on,
  output logic                cursor_on,
  output logic                blink_on,
  output logic [COUNT_W-1:0]  cmd_count,
  output logic                err_busy,
  output logic                err_addr,
  input  logic                err_clr
);
  localparam int unsigned CNT_W =
    $clog2(((BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT) + 1);

  state_t            state;
  bus_sample_t       smp;
  logic [CNT_W-1:0]  busy_cnt;
  logic [CELL_W-1:0] clr_idx;
  logic              id_inc;
  logic              en_lvl, en_fall_c, en_rise_c_unused;
  logic [DATA_W-1:0] ddram [CELLS];
  logic [DATA_W-1:0] rd_data;
  logic              rd_oe;

  en_sync_edge u_en_sync (
    .clk      (clk),
    .rst      (rst),
    .en_async (bus.lcd_en),
    .en_sync  (en_lvl),
    .rise_c   (en_rise_c_unused),
    .fall_c   (en_fall_c)
  );

  // rs/rw/data sampled alongside the first synchronizer stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) smp <= '0;
    else      smp <= '{rs: bus.lcd_rs, rw: bus.lcd_rw, data: bus.lcd_data_in};
  end

  cmd_t              cmd_c;
  logic              wr_ev_c, acc_c, rd_step_c, long_c, clear_c, addr_bad_c;
  logic [CELL_W-1:0] ac_cell_c;

  assign cmd_c      = decode_cmd(smp.data);
  assign wr_ev_c    = en_fall_c & ~smp.rw;
  assign acc_c      = wr_ev_c & ~busy;
  assign rd_step_c  = en_fall_c & smp.rw & smp.rs & ~busy;
  assign clear_c    = ~smp.rs & (cmd_c == CMD_CLEAR);
  assign long_c     = ~smp.rs & ((cmd_c == CMD_CLEAR) | (cmd_c == CMD_HOME));
  assign addr_bad_c = ~smp.rs & (cmd_c == CMD_DDRAM) & (smp.data[5:4] != 2'b00);
  assign ac_cell_c  = {ac[6], ac[3:0]};

  // Control FSM: accept writes when idle, sweep spaces during clear, count busy down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      busy_cnt  <= '0;
      clr_idx   <= '0;
      ac        <= '0;
      id_inc    <= 1'b1;
      disp_on   <= 1'b0;
      cursor_on <= 1'b0;
      blink_on  <= 1'b0;
      cmd_count <= '0;
      err_busy  <= 1'b0;
      err_addr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_c) begin
            busy     <= 1'b1;
            busy_cnt <= long_c ? CNT_W'(BUSY_LONG) : CNT_W'(BUSY_SHORT);
            clr_idx  <= '0;
            state    <= clear_c ? ST_CLEAR : ST_BUSY;
            if (cmd_count != '1) cmd_count <= cmd_count + COUNT_W'(1);
            if (smp.rs) begin
              ac <= ac_step(ac, id_inc);
            end else begin
              case (cmd_c)
                CMD_HOME:  ac <= '0;
                CMD_ENTRY: id_inc <= smp.data[1];
                CMD_DISP:  {disp_on, cursor_on, blink_on} <= smp.data[2:0];
                CMD_SHIFT: if (!smp.data[3]) ac <= ac_step(ac, smp.data[2]);
                CMD_DDRAM: if (smp.data[5:4] == 2'b00) ac <= smp.data[6:0];
                default: ;
              endcase
            end
          end else if (rd_step_c) begin
            ac <= ac_step(ac, id_inc);
          end
        end
        ST_CLEAR: begin
          busy_cnt <= busy_cnt - CNT_W'(1);
          clr_idx  <= clr_idx + CELL_W'(1);
          if (clr_idx == CELL_W'(CELLS - 1)) begin
            ac     <= '0;
            id_inc <= 1'b1;
            if (busy_cnt <= CNT_W'(1)) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          busy_cnt <= busy_cnt - CNT_W'(1);
          if (busy_cnt <= CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A new error takes precedence over a simultaneous clear.
      if (wr_ev_c && busy) err_busy <= 1'b1;
      else if (err_clr)    err_busy <= 1'b0;
      if (acc_c && addr_bad_c) err_addr <= 1'b1;
      else if (err_clr)        err_addr <= 1'b0;
    end
  end

  logic              wr_en_c;
  logic [CELL_W-1:0] wr_cell_c;
  logic [DATA_W-1:0] wr_data_c;

  always_comb begin
    wr_en_c   = 1'b0;
    wr_cell_c = ac_cell_c;
    wr_data_c = smp.data;
    if (state == ST_CLEAR) begin
      wr_en_c   = 1'b1;
      wr_cell_c = clr_idx;
      wr_data_c = SPACE;
    end else if (acc_c && smp.rs) begin
      wr_en_c   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CELLS; i++) ddram[i] <= SPACE;
    end else if (wr_en_c) begin
      ddram[wr_cell_c] <= wr_data_c;
    end
  end

  // Read-back path and monitor port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mon_char <= SPACE;
      rd_data  <= '0;
      rd_oe    <= 1'b0;
    end else begin
      mon_char <= ddram[mon_idx];
      rd_oe    <= en_lvl & smp.rw;
      if (en_lvl && smp.rw) rd_data <= smp.rs ? ddram[ac_cell_c] : {busy, ac};
      else                  rd_data <= '0;
    end
  end

  assign bus.lcd_data_out = rd_data;
  assign bus.lcd_data_oe  = rd_oe;
endmodule

// File: tb/tb_lcd_bus_responder.sv
// Directed bench for lcd_bus_responder with hand-computed expectations.
module tb_lcd_bus_responder;
  import lcd_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mon_idx;
  logic [7:0]  mon_char;
  logic        busy;
  logic [6:0]  ac;
  logic        disp_on, cursor_on, blink_on;
  logic [15:0] cmd_count;
  logic        err_busy, err_addr, err_clr;

  int errors = 0;
  int checks = 0;

  lcd_bus_responder_if bus ();

  lcd_bus_responder #(.BUSY_SHORT(40), .BUSY_LONG(1640)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .mon_idx   (mon_idx),
    .mon_char  (mon_char),
    .busy      (busy),
    .ac        (ac),
    .disp_on   (disp_on),
    .cursor_on (cursor_on),
    .blink_on  (blink_on),
    .cmd_count (cmd_count),
    .err_busy  (err_busy),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write cycle: event lands 3 edges after en falls; returns one edge after the action.
  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = 1'b0; bus.lcd_data_in = d;
    @(posedge clk); #1 bus.lcd_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.lcd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic rs, output logic [7:0] dout, output logic oe);
    @(posedge clk); #1;
    bus.lcd_rs = rs; bus.lcd_rw = 1'b1; bus.lcd_data_in = 8'h00;
    @(posedge clk); #1 bus.lcd_en = 1'b1;
    repeat (4) @(posedge clk);
    #1 dout = bus.lcd_data_out; oe = bus.lcd_data_oe;
    bus.lcd_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  task automatic peek(input logic [4:0] idx, output logic [7:0] v);
    mon_idx = idx;
    @(posedge clk); #1 v = mon_char;
  endtask

  task automatic pulse_rst();
    #1 rst = 1'b0;
  endtask

  logic [7:0] v;
  logic       oe;
  int         nonspace;

  initial begin
    rst = 1'b1; err_clr = 1'b0; mon_idx = '0;
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_data_in = '0;
    #2 rst = 1'b0;
    #1;
    check("rst_dout", 32'(bus.lcd_data_out), 32'h0);
    check("rst_oe", 32'(bus.lcd_data_oe), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ac", 32'(ac), 32'h0);
    check("rst_dcb", 32'({disp_on, cursor_on, blink_on}), 32'h0);
    check("rst_cnt", 32'(cmd_count), 32'h0);
    check("rst_err", 32'({err_busy, err_addr}), 32'h0);
    check("rst_mon", 32'(mon_char), 32'h20);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Display control 0x0C and exact 40-cycle busy window
    bus_write(1'b0, 8'h0C);
    check("dc_dcb", 32'({disp_on, cursor_on, blink_on}), 32'h4);
    check("dc_busy", 32'(busy), 32'h1);
    check("dc_cnt", 32'(cmd_count), 32'h1);
    repeat (38) @(posedge clk);
    #1 check("dc_busy_last", 32'(busy), 32'h1);
    @(posedge clk); #1 check("dc_busy_end", 32'(busy), 32'h0);

    // Line-1 to line-2 wrap on data writes
    bus_write(1'b0, 8'h8F); wait_idle("idle_8f");
    check("ac_8f", 32'(ac), 32'h0F);
    bus_write(1'b1, 8'h41); wait_idle("idle_41");
    check("ac_wrap", 32'(ac), 32'h40);
    bus_write(1'b1, 8'h42); wait_idle("idle_42");
    check("ac_41", 32'(ac), 32'h41);
    peek(5'd15, v); check("cell15", 32'(v), 32'h41);
    peek(5'd16, v); check("cell16", 32'(v), 32'h42);
    check("cnt4", 32'(cmd_count), 32'h4);

    // Data read returns DDRAM[AC] and steps AC
    bus_write(1'b0, 8'hC0); wait_idle("idle_c0");
    bus_read(1'b1, v, oe);
    check("rd_data", 32'(v), 32'h42);
    check("rd_oe", 32'(oe), 32'h1);
    check("rd_step", 32'(ac), 32'h41);
    check("rd_oe_off", 32'(bus.lcd_data_oe), 32'h0);

    // Status read during and after busy
    bus_write(1'b0, 8'h80);
    bus_read(1'b0, v, oe);
    check("st_busy", 32'(v), 32'h80);
    wait_idle("idle_80");
    bus_read(1'b0, v, oe);
    check("st_idle", 32'(v), 32'h00);
    check("st_ac", 32'(ac), 32'h00);
    check("cnt6", 32'(cmd_count), 32'h6);

    // Decrement mode, shifts, display bits, no-op opcodes
    bus_write(1'b0, 8'h04); wait_idle("idle_04");
    bus_write(1'b1, 8'h55); wait_idle("idle_55");
    check("dec_wrap", 32'(ac), 32'h4F);
    peek(5'd0, v); check("cell0_55", 32'(v), 32'h55);
    bus_write(1'b0, 8'h14); wait_idle("idle_14");
    check("shift_r", 32'(ac), 32'h00);
    bus_write(1'b0, 8'h10); wait_idle("idle_10");
    check("shift_l", 32'(ac), 32'h4F);
    bus_write(1'b0, 8'h18); wait_idle("idle_18");
    check("shift_sc", 32'(ac), 32'h4F);
    bus_write(1'b0, 8'h0F); wait_idle("idle_0f");
    check("dcb_all", 32'({disp_on, cursor_on, blink_on}), 32'h7);
    bus_write(1'b0, 8'h00);
    check("nop_busy", 32'(busy), 32'h1);
    wait_idle("idle_00");
    bus_write(1'b0, OP_FUNC | 8'h10); wait_idle("idle_30");
    bus_write(1'b0, OP_CGRAM); wait_idle("idle_40");
    check("nop_ac", 32'(ac), 32'h4F);
    check("cnt15", 32'(cmd_count), 32'hF);

    // Out-of-map DDRAM address
    bus_write(1'b0, 8'h95); wait_idle("idle_95");
    check("addr_err", 32'(err_addr), 32'h1);
    check("addr_ac", 32'(ac), 32'h4F);
    check("cnt16", 32'(cmd_count), 32'h10);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    check("addr_clr", 32'(err_addr), 32'h0);

    // Clear with a write arriving while busy
    bus_write(1'b0, OP_CLEAR);
    bus_write(1'b1, 8'h77);
    check("busy_err", 32'(err_busy), 32'h1);
    check("cnt17", 32'(cmd_count), 32'h11);
    repeat (1629) @(posedge clk);
    #1 check("clr_busy_last", 32'(busy), 32'h1);
    @(posedge clk); #1 check("clr_busy_end", 32'(busy), 32'h0);
    check("clr_ac", 32'(ac), 32'h00);
    nonspace = 0;
    for (int i = 0; i < 32; i++) begin
      peek(5'(i), v);
      if (v !== 8'h20) nonspace++;
    end
    check("clr_cells", 32'(nonspace), 32'h0);
    bus_write(1'b1, 8'h31); wait_idle("idle_31");
    check("clr_id_inc", 32'(ac), 32'h01);
    peek(5'd0, v); check("cell0_31", 32'(v), 32'h31);

    // Asynchronous reset aborts busy and clear
    bus_write(1'b0, 8'h0C);
    pulse_rst();
    #1;
    check("rst_mid_busy", 32'(busy), 32'h0);
    check("rst_mid_disp", 32'(disp_on), 32'h0);
    check("rst_mid_cnt", 32'(cmd_count), 32'h0);
    #1 rst = 1'b1;
    bus_write(1'b0, OP_CLEAR);
    repeat (5) @(posedge clk);
    pulse_rst();
    #1 check("rst_mid_clr", 32'(busy), 32'h0);
    #1 rst = 1'b1;
    bus_write(1'b1, 8'h62); wait_idle("idle_62");
    check("post_rst_ac", 32'(ac), 32'h01);
    check("post_rst_cnt", 32'(cmd_count), 32'h1);
    peek(5'd0, v); check("post_rst_cell", 32'(v), 32'h62);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
